// File: rtl/rv_branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv_branch_predictor_if
//  Description : Fetch-lookup and execute-resolve signal bundle between the
//                rv32i pipeline and the branch history/target table.
//  Revision    : 1.0  initial release
// ============================================================================
interface rv_branch_predictor_if #(
   parameter int XLEN = 32
);
   // Fetch-side lookup
   logic [XLEN-1:0] if_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   // Execute-side resolution
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_is_taken;
   logic [XLEN-1:0] upd_target;
   logic            upd_pred_taken;
   logic [XLEN-1:0] upd_pred_target;
   // Mispredict redirect
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   // Performance counters
   logic [31:0]     num_branches;
   logic [31:0]     num_mispredicts;

   // Pipeline side: drives lookups and resolved branches
   modport master (
      output if_pc,
      input  pred_taken,
      input  pred_target,
      output upd_valid,
      output upd_pc,
      output upd_is_taken,
      output upd_target,
      output upd_pred_taken,
      output upd_pred_target,
      input  redirect_valid,
      input  redirect_pc,
      input  num_branches,
      input  num_mispredicts
   );

   // Predictor side
   modport slave (
      input  if_pc,
      output pred_taken,
      output pred_target,
      input  upd_valid,
      input  upd_pc,
      input  upd_is_taken,
      input  upd_target,
      input  upd_pred_taken,
      input  upd_pred_target,
      output redirect_valid,
      output redirect_pc,
      output num_branches,
      output num_mispredicts
   );
endinterface
`default_nettype wire

// File: rtl/rv_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : rv_branch_predictor
//  Description : Direct-mapped BHT+BTB. Zero-cycle lookup of the fetch PC,
//                same-cycle mispredict detection for resolved branches,
//                2-bit counter training and entry allocation on the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8
) (
   input  wire logic              i_clk,
   input  wire logic              i_rst,
   rv_branch_predictor_if.slave   bp
);
   localparam int              IDX_W  = $clog2(ENTRIES);
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);
   localparam logic [1:0]      CTR_RST   = 2'b01;
   localparam logic [1:0]      CTR_ALLOC = 2'b10;

   // Table storage
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mis_cnt_q, mis_cnt_d;

   // Index/tag extraction; the byte-offset bits and PC bits above the tag
   // do not participate in the lookup.
   logic [IDX_W-1:0] lkp_idx_w, upd_idx_w;
   logic [TAG_W-1:0] lkp_tag_w, upd_tag_w;
   logic             unused_pc_bits_w;

   assign lkp_idx_w = bp.if_pc[IDX_W+1:2];
   assign lkp_tag_w = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_idx_w = bp.upd_pc[IDX_W+1:2];
   assign upd_tag_w = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign unused_pc_bits_w = ^{bp.if_pc, bp.upd_pc};

   logic lkp_hit_w;
   logic upd_hit_w;

   // Fetch lookup: reads pre-update table contents, no write bypass
   always_comb begin
      lkp_hit_w      = valid_q[lkp_idx_w] && (tag_q[lkp_idx_w] == lkp_tag_w);
      bp.pred_taken  = lkp_hit_w && ctr_q[lkp_idx_w][1];
      bp.pred_target = bp.pred_taken ? target_q[lkp_idx_w] : (bp.if_pc + PC_INC);
   end

   logic [XLEN-1:0] act_next_w;

   // Resolve: compare actual next PC against what fetch followed
   always_comb begin
      act_next_w        = bp.upd_is_taken ? bp.upd_target : (bp.upd_pc + PC_INC);
      bp.redirect_valid = bp.upd_valid && (act_next_w != bp.upd_pred_target);
      bp.redirect_pc    = bp.upd_valid ? act_next_w : '0;
   end

   logic             entry_we_w;
   logic [XLEN-1:0]  target_d;
   logic [1:0]       ctr_d;

   // Training: saturating counter on hit, weakly-taken allocate on taken miss
   always_comb begin
      upd_hit_w  = valid_q[upd_idx_w] && (tag_q[upd_idx_w] == upd_tag_w);
      entry_we_w = 1'b0;
      target_d   = target_q[upd_idx_w];
      ctr_d      = ctr_q[upd_idx_w];
      if (bp.upd_valid) begin
         if (upd_hit_w) begin
            entry_we_w = 1'b1;
            if (bp.upd_is_taken) begin
               target_d = bp.upd_target;
               ctr_d    = (ctr_q[upd_idx_w] == 2'b11) ? 2'b11 : ctr_q[upd_idx_w] + 2'b01;
            end else begin
               ctr_d    = (ctr_q[upd_idx_w] == 2'b00) ? 2'b00 : ctr_q[upd_idx_w] - 2'b01;
            end
         end else if (bp.upd_is_taken) begin
            entry_we_w = 1'b1;
            target_d   = bp.upd_target;
            ctr_d      = CTR_ALLOC;
         end
      end
   end

   // Table state: reset clears every entry, otherwise write the updated entry
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RST;
         end
      end else if (entry_we_w) begin
         valid_q[upd_idx_w]  <= 1'b1;
         tag_q[upd_idx_w]    <= upd_tag_w;
         target_q[upd_idx_w] <= target_d;
         ctr_q[upd_idx_w]    <= ctr_d;
      end
   end

   // Saturating performance counter next-state
   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (bp.upd_valid && (br_cnt_q != 32'hFFFF_FFFF)) begin
         br_cnt_d = br_cnt_q + 32'd1;
      end
      if (bp.redirect_valid && (mis_cnt_q != 32'hFFFF_FFFF)) begin
         mis_cnt_d = mis_cnt_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign bp.num_branches    = br_cnt_q;
   assign bp.num_mispredicts = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_branch_predictor
//  Description : Directed self-checking bench for rv_branch_predictor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_branch_predictor;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rv_branch_predictor_if #(.XLEN(32)) bp ();

   rv_branch_predictor #(
      .XLEN    (32),
      .ENTRIES (64),
      .TAG_W   (8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bp    (bp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, land 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic ptaken, input logic [31:0] ptgt);
      bp.upd_valid       = 1'b1;
      bp.upd_pc          = pc;
      bp.upd_is_taken    = taken;
      bp.upd_target      = tgt;
      bp.upd_pred_taken  = ptaken;
      bp.upd_pred_target = ptgt;
      #1;
   endtask

   task automatic idle();
      bp.upd_valid       = 1'b0;
      bp.upd_pc          = '0;
      bp.upd_is_taken    = 1'b0;
      bp.upd_target      = '0;
      bp.upd_pred_taken  = 1'b0;
      bp.upd_pred_target = '0;
      #1;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                       input logic [31:0] exp_tgt);
      bp.if_pc = pc;
      #1;
      chk({tag, "_taken"},  {31'd0, bp.pred_taken}, {31'd0, exp_t});
      chk({tag, "_target"}, bp.pred_target, exp_tgt);
   endtask

   task automatic redir(input string tag, input logic exp_v, input logic [31:0] exp_pc);
      chk({tag, "_rvalid"}, {31'd0, bp.redirect_valid}, {31'd0, exp_v});
      chk({tag, "_rpc"},    bp.redirect_pc, exp_pc);
   endtask

   task automatic cnts(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
      chk({tag, "_nbr"},  bp.num_branches,    exp_b);
      chk({tag, "_nmis"}, bp.num_mispredicts, exp_m);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bp.if_pc = '0;
      idle();
      tick();
      tick();
      rst = 1'b0;

      // 1: reset state
      look("rst_lkp", 32'h100, 1'b0, 32'h104);
      cnts("rst", 0, 0);
      look("wrap_lkp", 32'hFFFF_FFFC, 1'b0, 32'h0);
      redir("idle0", 1'b0, 32'h0);

      // 2: first taken resolve allocates and mispredicts
      upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      redir("alloc", 1'b1, 32'h80);
      tick();
      idle();
      look("alloc_lkp", 32'h100, 1'b1, 32'h80);
      cnts("alloc", 1, 1);

      // 3: train up to strong-taken, then two not-taken
      for (int i = 0; i < 3; i++) begin
         upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
         redir("train_t", 1'b0, 32'h80);
         tick();
      end
      upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      redir("nt1", 1'b1, 32'h104);
      tick();
      idle();
      look("nt1_lkp", 32'h100, 1'b1, 32'h80);
      upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      tick();
      idle();
      look("nt2_lkp", 32'h100, 1'b0, 32'h104);
      cnts("train", 6, 3);

      // 4: aliasing replaces the entry at index 0
      upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
      redir("alias", 1'b1, 32'h300);
      tick();
      idle();
      look("alias_old", 32'h100, 1'b0, 32'h104);
      look("alias_new", 32'h200, 1'b1, 32'h300);

      // miss and not-taken leaves the table alone
      upd(32'h500, 1'b0, 32'h700, 1'b0, 32'h504);
      redir("miss_nt", 1'b0, 32'h504);
      tick();
      idle();
      look("miss_nt_lkp", 32'h200, 1'b1, 32'h300);
      look("miss_nt_500", 32'h500, 1'b0, 32'h504);
      cnts("alias", 8, 4);

      // 5: target-only mismatch
      upd(32'h200, 1'b1, 32'h390, 1'b1, 32'h300);
      redir("tgt", 1'b1, 32'h390);
      tick();
      idle();
      look("tgt_lkp", 32'h200, 1'b1, 32'h390);

      // 6: same-cycle lookup and update sees old contents
      bp.if_pc = 32'h200;
      upd(32'h200, 1'b0, 32'h390, 1'b1, 32'h390);
      look("same_pre", 32'h200, 1'b1, 32'h390);
      redir("same", 1'b1, 32'h204);
      tick();
      idle();
      look("same_post", 32'h200, 1'b1, 32'h390);
      cnts("same", 10, 6);

      // reset wins over a simultaneous update
      rst = 1'b1;
      upd(32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
      tick();
      rst = 1'b0;
      idle();
      look("rst2_lkp", 32'h200, 1'b0, 32'h204);
      cnts("rst2", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
